// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : two-requester front end sharing one combinational ALU.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin ties (default: fixed priority).
// Rev 1.0
// ============================================================================
module alu_arbiter #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*XLEN-1:0] req_op0,
  input  logic [2*XLEN-1:0] req_op1,
  input  logic [19:0]       req_fn,
  output logic [XLEN-1:0]   alu_op0,
  output logic [XLEN-1:0]   alu_op1,
  output logic [2:0]        alu_func3,
  output logic [6:0]        alu_func7,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [XLEN-1:0]   rsp_result,
  output logic              rsp_overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              grant_id;
  logic              grant_en;
  logic              owner;
  logic [XLEN-1:0]   sel_op0;
  logic [XLEN-1:0]   sel_op1;
  logic [9:0]        sel_fn;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic              last_grant;
`endif

  // Tie-break: round-robin against the previous winner, or requester 0 always.
  always_comb begin
    grant_id = 1'b0;
    if (req_valid == 2'b10) begin
      grant_id = 1'b1;
    end else if (req_valid == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      grant_id = ~last_grant;
`else
      grant_id = 1'b0;
`endif
    end
  end

  assign sel_op0 = grant_id ? req_op0[2*XLEN-1:XLEN] : req_op0[XLEN-1:0];
  assign sel_op1 = grant_id ? req_op1[2*XLEN-1:XLEN] : req_op1[XLEN-1:0];
  assign sel_fn  = grant_id ? req_fn[19:10]          : req_fn[9:0];

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_en  = 1'b1;
          // Gate with rst_n so nothing looks accepted while reset is held.
          req_ready = rst_n ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op0   <= '0;
      alu_op1   <= '0;
      alu_func3 <= 3'd0;
      alu_func7 <= 7'd0;
      owner     <= 1'b0;
    end else if (grant_en) begin
      alu_op0   <= sel_op0;
      alu_op1   <= sel_op1;
      alu_func3 <= sel_fn[2:0];
      alu_func7 <= sel_fn[9:3];
      owner     <= grant_id;
    end
  end

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (grant_en) begin
      last_grant <= grant_id;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id       <= owner;
      rsp_result   <= alu_result;
      rsp_overflow <= alu_overflow;
    end
  end

  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    req_ready != 2'b11);

  a_rsp_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_result) && $stable(rsp_id)));

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// Scoreboard bench for alu_arbiter: directed requests, a behavioural ALU
// on the alu_* side, and a monitor that checks every presented response.
module tb_alu_arbiter;
  localparam int XLEN = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*XLEN-1:0] req_op0;
  logic [2*XLEN-1:0] req_op1;
  logic [19:0]       req_fn;
  logic [XLEN-1:0]   alu_op0;
  logic [XLEN-1:0]   alu_op1;
  logic [2:0]        alu_func3;
  logic [6:0]        alu_func7;
  logic [XLEN-1:0]   alu_result;
  logic              alu_overflow;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [XLEN-1:0]   rsp_result;
  logic              rsp_overflow;

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_fn(req_fn),
    .alu_op0(alu_op0), .alu_op1(alu_op1),
    .alu_func3(alu_func3), .alu_func7(alu_func7),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow)
  );

  always #5 clk = ~clk;

  // ALU: func7[5] selects subtract; overflow is carry-out / borrow.
  logic [XLEN:0] alu_wide;
  always_comb begin
    if (alu_func7[5]) alu_wide = {1'b0, alu_op0} - {1'b0, alu_op1};
    else              alu_wide = {1'b0, alu_op0} + {1'b0, alu_op1};
  end
  assign alu_result   = alu_wide[XLEN-1:0];
  assign alu_overflow = alu_wide[XLEN];

  typedef struct {
    logic            id;
    logic [XLEN-1:0] res;
    logic            ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic id, input logic [XLEN-1:0] res, input logic ovf);
    exp_t e;
    e.id = id; e.res = res; e.ovf = ovf;
    q.push_back(e);
  endtask

  // Monitor: every presented response must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d result=%h with no response expected",
                 rsp_id, rsp_result);
      end else begin
        chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
        chk("rsp_result", rsp_result, q[0].res);
        chk("rsp_overflow", 64'(rsp_overflow), 64'(q[0].ovf));
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [6:0] f7, input logic [2:0] f3);
    if (id) begin
      req_op0[2*XLEN-1:XLEN] = a;
      req_op1[2*XLEN-1:XLEN] = b;
      req_fn[19:10]          = {f7, f3};
    end else begin
      req_op0[XLEN-1:0] = a;
      req_op1[XLEN-1:0] = b;
      req_fn[9:0]       = {f7, f3};
    end
  endtask

  task automatic wait_grant(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got req_ready=%b expected a grant", req_ready);
    end
  endtask

  task automatic wait_rsp();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got rsp_valid=0 expected 1");
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    logic exp_id;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_op0   = '0;
    req_op1   = '0;
    req_fn    = '0;
    rsp_ready = 1'b0;
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_result", rsp_result, 64'd0);
    chk("rst_rsp_overflow", 64'(rsp_overflow), 64'd0);
    chk("rst_alu_op0", alu_op0, 64'd0);
    chk("rst_alu_op1", alu_op1, 64'd0);
    chk("rst_alu_func3", 64'(alu_func3), 64'd0);
    chk("rst_alu_func7", 64'(alu_func7), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single add from requester 0: 5 + 3 = 8, response two cycles after grant.
    set_req(1'b0, 64'd5, 64'd3, 7'h00, 3'd0);
    req_valid = 2'b01;
    @(negedge clk);
    chk("add_req_ready", 64'(req_ready), 64'd1);
    push(1'b0, 64'd8, 1'b0);
    tick();
    req_valid = 2'b00;
    chk("add_alu_op0", alu_op0, 64'd5);
    chk("add_alu_op1", alu_op1, 64'd3);
    chk("add_alu_func3", 64'(alu_func3), 64'd0);
    chk("add_alu_func7", 64'(alu_func7), 64'd0);
    chk("add_rsp_valid_exec", 64'(rsp_valid), 64'd0);
    tick();
    chk("add_rsp_valid_resp", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    wait_drain();
    tick();

    // Both requesting continuously from reset.
    rst_n = 1'b0;
    #10;
    rst_n = 1'b1;
    set_req(1'b0, 64'd10, 64'd20, 7'h00, 3'd0);
    set_req(1'b1, 64'd100, 64'd1, 7'h20, 3'd0);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(ok);
      if (!ok) break;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_id = (k % 2) == 1;
`else
      exp_id = 1'b0;
`endif
      chk("tie_grant", 64'(req_ready), exp_id ? 64'd2 : 64'd1);
      if (exp_id) push(1'b1, 64'd99, 1'b0);
      else        push(1'b0, 64'd30, 1'b0);
      tick();
    end
    req_valid = 2'b00;
    wait_drain();
    tick();
    rsp_ready = 1'b0;

    // Requester 1: 1 - 2 wraps to all ones with borrow; consumer stalls.
    set_req(1'b1, 64'd1, 64'd2, 7'h20, 3'd0);
    req_valid = 2'b10;
    wait_grant(ok);
    chk("sub_req_ready", 64'(req_ready), 64'd2);
    push(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    tick();
    req_valid = 2'b00;
    wait_rsp();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_drain();
    tick();
    rsp_ready = 1'b0;

    // Requester 0 arrives while requester 1 is in flight: stalls, then wins.
    set_req(1'b1, 64'd50, 64'd8, 7'h20, 3'd0);
    req_valid = 2'b10;
    wait_grant(ok);
    chk("busy_first_grant", 64'(req_ready), 64'd2);
    push(1'b1, 64'd42, 1'b0);
    tick();
    set_req(1'b0, 64'h1234, 64'h1111, 7'h00, 3'd0);
    req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("busy_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_grant(ok);
    chk("busy_second_grant", 64'(req_ready), 64'd1);
    push(1'b0, 64'h2345, 1'b0);
    tick();
    req_valid = 2'b00;
    wait_drain();
    tick();
    rsp_ready = 1'b0;

    // Reset while a response is pending discards it.
    set_req(1'b0, 64'd7, 64'd9, 7'h00, 3'd0);
    req_valid = 2'b01;
    wait_grant(ok);
    push(1'b0, 64'd16, 1'b0);
    tick();
    req_valid = 2'b00;
    wait_rsp();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstresp_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstresp_rsp_result", rsp_result, 64'd0);
    chk("rstresp_rsp_id", 64'(rsp_id), 64'd0);
    chk("rstresp_rsp_overflow", 64'(rsp_overflow), 64'd0);
    chk("rstresp_alu_op0", alu_op0, 64'd0);
    chk("rstresp_alu_op1", alu_op1, 64'd0);
    q.delete();
    set_req(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 7'h00, 3'd0);
    req_valid = 2'b01;
    #1;
    chk("rstheld_req_ready", 64'(req_ready), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("release_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("release_first_grant", 64'(req_ready), 64'd1);
    push(1'b0, 64'd0, 1'b1);
    rsp_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    wait_drain();
    tick();

    // Idle with rsp_ready high: nothing granted, nothing presented.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_req_ready", 64'(req_ready), 64'd0);
      chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
